// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and helpers for the FIFO read-side stream controller.
//   rd_state_t   : controller state (IDLE, RUN, DRAIN)
//   WORD_CNT_W   : width of the delivered-word counter
//   count_width  : bits needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int WORD_CNT_W = 16;

    // An occupancy counter must represent every value from 0 up to and
    // including a completely full buffer, hence depth+1 distinct values.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_buf.sv
// -----------------------------------------------------------------------------
// stream_buf
// Small circular elastic buffer. Handles simultaneous push and pop with the
// count unchanged and order preserved; pointers wrap at BUF_DEPTH, so the
// depth need not be a power of two.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : word to store
//   pop        : remove the head entry
//   count      : current occupancy (0..BUF_DEPTH)
//   head_data  : oldest stored word, zero while empty
// -----------------------------------------------------------------------------
module stream_buf
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUF_DEPTH  = 2,
    localparam int CW         = count_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int            PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(BUF_DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer that is popping this same cycle frees the slot the
    // write lands in, so the push is still safe.
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so the stream data is clean
    // out of reset and between bursts.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array: plain registers, no reset needed since the head is
    // masked whenever the buffer holds nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy; push-with-pop leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side controller for the synchronous FIFO. Issues read enables against
// the empty flag, tracks reads in flight across the FIFO's fixed read latency,
// captures returning words into an elastic buffer and presents them as a
// valid/ready stream.
//   i_Clk, i_Reset   : clock, asynchronous active-high reset
//   i_Enable         : allow new reads; low starts a drain
//   o_Rd_En          : FIFO read enable
//   i_Empty          : FIFO empty flag
//   i_Rd_Data        : FIFO read data
//   i_Data_Valid     : FIFO read data valid
//   o_Data, o_Valid  : stream data / valid (head of the buffer)
//   i_Ready          : stream ready from the consumer
//   o_Idle           : nothing in flight, buffer empty, not running (registered)
//   o_Word_Count     : words delivered downstream, wraps at 2^16
//   o_Proto_Err      : sticky, data valid seen with no read outstanding
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Enable,
    output logic                  o_Rd_En,
    input  logic                  i_Empty,
    input  logic [DATA_WIDTH-1:0] i_Rd_Data,
    input  logic                  i_Data_Valid,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Idle,
    output logic [WORD_CNT_W-1:0] o_Word_Count,
    output logic                  o_Proto_Err
);

    localparam int CW = count_width(BUF_DEPTH);
    localparam int SW = CW + 1;

    rd_state_t             state;
    rd_state_t             state_next;
    logic [RD_LATENCY-1:0] inflight_sr;
    logic [SW-1:0]         inflight;
    logic [SW-1:0]         occupancy;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;

    // Elastic buffer holding captured words until the consumer takes them.
    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (i_Clk),
        .rst       (i_Reset),
        .push      (push),
        .push_data (i_Rd_Data),
        .pop       (pop),
        .count     (count),
        .head_data (o_Data)
    );

    assign o_Valid   = (count != '0);
    assign pop       = o_Valid && i_Ready;
    assign push      = i_Data_Valid && (inflight != '0);
    assign occupancy = SW'(count) + inflight;

    // Number of reads issued whose data has not yet come back.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SW'(inflight_sr[i]);
        end
    end

    // Read issue with credit check: every issued read reserves a buffer slot
    // until its word is popped, so a returning word always has a home. A slot
    // being popped this cycle is already free by the time any new read can
    // return, which is what lets BUF_DEPTH=RD_LATENCY+1 sustain one word per
    // cycle.
    always_comb begin
        o_Rd_En = (state == RUN) && i_Enable && !i_Empty &&
                  (occupancy < (SW'(BUF_DEPTH) + SW'(pop)));
    end

    // Next-state logic: drain finishes only once every outstanding read has
    // returned and the consumer has emptied the buffer.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (i_Enable) state_next = RUN;
            RUN:     if (!i_Enable) state_next = DRAIN;
            DRAIN: begin
                if (i_Enable) begin
                    state_next = RUN;
                end else if ((inflight == '0) && (count == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In-flight shift register: a read enters at bit 0 and falls off the top
    // on the cycle its data returns, retiring its credit.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            inflight_sr <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | RD_LATENCY'(o_Rd_En);
        end
    end

    // Status: registered idle, delivered-word counter and the sticky
    // protocol error for data that nobody asked for.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Idle       <= 1'b1;
            o_Word_Count <= '0;
            o_Proto_Err  <= 1'b0;
        end else begin
            o_Idle <= (state == IDLE) && (inflight == '0) && (count == '0);
            if (pop) begin
                o_Word_Count <= o_Word_Count + WORD_CNT_W'(1);
            end
            if (i_Data_Valid && (inflight == '0)) begin
                o_Proto_Err <= 1'b1;
            end
        end
    end

endmodule
